// File: rtl/procyon_biu_wb.sv
// procyon_biu_wb -- Bus Interface Unit, Wishbone classic master.
//
// Takes one request at a time from the CCU arbiter and runs it as a Wishbone
// classic cycle. A line request becomes a burst of single-beat transfers at
// ascending bus-word addresses. A byte, half or word request becomes one beat
// with lane selects derived from the low address bits. Completion is reported
// with a one-cycle done pulse that carries the assembled read line.
//
// Ports:
//   clk, n_rst            clock, asynchronous active-low reset
//   i_biu_en              request valid, held by the arbiter until after done
//   i_biu_func            read / write
//   i_biu_len             0 byte, 1 half, 2 word, 3 line
//   i_biu_addr            byte address
//   i_biu_data            write data (sub-word data in the low bits)
//   o_biu_done            one-cycle completion pulse
//   o_biu_data            read line, valid with done and held afterwards
//   o_wb_cyc/stb/we       Wishbone cycle, strobe, write enable
//   o_wb_sel              byte-lane selects
//   o_wb_addr             bus-word aligned byte address
//   o_wb_data             write data
//   i_wb_ack, i_wb_data   beat acknowledge, read data
//
// All outputs come straight from flops.

`ifndef PCYN_BIU_FUNC_WIDTH
`define PCYN_BIU_FUNC_WIDTH 1
`endif
`ifndef PCYN_BIU_FUNC_READ
`define PCYN_BIU_FUNC_READ 1'b0
`endif
`ifndef PCYN_BIU_FUNC_WRITE
`define PCYN_BIU_FUNC_WRITE 1'b1
`endif
`ifndef PCYN_BIU_LEN_WIDTH
`define PCYN_BIU_LEN_WIDTH 2
`endif
`ifndef PCYN_BIU_LEN_BYTE
`define PCYN_BIU_LEN_BYTE 2'd0
`endif
`ifndef PCYN_BIU_LEN_HALF
`define PCYN_BIU_LEN_HALF 2'd1
`endif
`ifndef PCYN_BIU_LEN_WORD
`define PCYN_BIU_LEN_WORD 2'd2
`endif
`ifndef PCYN_BIU_LEN_LINE
`define PCYN_BIU_LEN_LINE 2'd3
`endif

module procyon_biu_wb #(
  parameter int OPTN_ADDR_WIDTH    = 32,
  parameter int OPTN_CCU_LINE_SIZE = 32,
  parameter int OPTN_WB_DATA_WIDTH = 32,
  parameter int CCU_LINE_WIDTH     = OPTN_CCU_LINE_SIZE * 8
) (
  input  logic                              clk,
  input  logic                              n_rst,

  input  logic                              i_biu_en,
  input  logic [`PCYN_BIU_FUNC_WIDTH-1:0]   i_biu_func,
  input  logic [`PCYN_BIU_LEN_WIDTH-1:0]    i_biu_len,
  input  logic [OPTN_ADDR_WIDTH-1:0]        i_biu_addr,
  input  logic [CCU_LINE_WIDTH-1:0]         i_biu_data,
  output logic                              o_biu_done,
  output logic [CCU_LINE_WIDTH-1:0]         o_biu_data,

  output logic                              o_wb_cyc,
  output logic                              o_wb_stb,
  output logic                              o_wb_we,
  output logic [OPTN_WB_DATA_WIDTH/8-1:0]   o_wb_sel,
  output logic [OPTN_ADDR_WIDTH-1:0]        o_wb_addr,
  output logic [OPTN_WB_DATA_WIDTH-1:0]     o_wb_data,
  input  logic                              i_wb_ack,
  input  logic [OPTN_WB_DATA_WIDTH-1:0]     i_wb_data
);

  localparam int WBW      = OPTN_WB_DATA_WIDTH;
  localparam int WB_BYTES = WBW / 8;
  localparam int SEL_W    = WB_BYTES;
  localparam int BEATS    = OPTN_CCU_LINE_SIZE / WB_BYTES;
  localparam int BEAT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [OPTN_ADDR_WIDTH-1:0] LINE_MASK = ~(OPTN_ADDR_WIDTH'(OPTN_CCU_LINE_SIZE - 1));
  localparam logic [OPTN_ADDR_WIDTH-1:0] BUS_MASK  = ~(OPTN_ADDR_WIDTH'(WB_BYTES - 1));
  localparam logic [OPTN_ADDR_WIDTH-1:0] BEAT_STEP = OPTN_ADDR_WIDTH'(WB_BYTES);
  localparam logic [BEAT_W-1:0]          LINE_LAST = BEAT_W'(BEATS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Byte offset of an address within one bus word.
  function automatic int bus_off(input logic [OPTN_ADDR_WIDTH-1:0] addr);
    return int'(addr & ~BUS_MASK);
  endfunction

  // Lane selects for a single-beat access; low bits below the access size are dropped.
  function automatic logic [SEL_W-1:0] sub_sel(input logic [`PCYN_BIU_LEN_WIDTH-1:0] len,
                                               input int off);
    logic [SEL_W-1:0] sel;
    case (len)
      `PCYN_BIU_LEN_BYTE: sel = SEL_W'(1'b1) << off;
      `PCYN_BIU_LEN_HALF: sel = SEL_W'(2'b11) << ((off / 2) * 2);
      `PCYN_BIU_LEN_WORD: begin
        if (WB_BYTES > 4) begin
          sel = SEL_W'(4'hF) << ((off / 4) * 4);
        end else begin
          sel = '1;
        end
      end
      default: sel = '1;
    endcase
    return sel;
  endfunction

  state_t                      state_q, state_d;
  logic                        cyc_q, cyc_d;
  logic                        stb_q, stb_d;
  logic                        we_q, we_d;
  logic [SEL_W-1:0]            sel_q, sel_d;
  logic [OPTN_ADDR_WIDTH-1:0]  wb_addr_q, wb_addr_d;
  logic [WBW-1:0]              wb_data_q, wb_data_d;
  logic                        done_q, done_d;
  logic [CCU_LINE_WIDTH-1:0]   biu_data_q, biu_data_d;
  logic [CCU_LINE_WIDTH-1:0]   wdata_q, wdata_d;   // latched write line
  logic [CCU_LINE_WIDTH-1:0]   rbuf_q, rbuf_d;     // read line being assembled
  logic [BEAT_W-1:0]           beat_q, beat_d;
  logic [BEAT_W-1:0]           last_q, last_d;     // index of final beat

  logic [WBW-1:0]              sub_wdata_s;
  int                          off_s;

  // Sub-word write data moved up to the lane addressed by the request.
  always_comb begin
    off_s       = bus_off(i_biu_addr);
    sub_wdata_s = i_biu_data[WBW-1:0];
    sub_wdata_s = sub_wdata_s << (off_s * 8);
  end

  // Next-state and output computation for the IDLE/BUSY/DONE sequencer.
  always_comb begin
    state_d    = state_q;
    cyc_d      = cyc_q;
    stb_d      = stb_q;
    we_d       = we_q;
    sel_d      = sel_q;
    wb_addr_d  = wb_addr_q;
    wb_data_d  = wb_data_q;
    done_d     = 1'b0;
    biu_data_d = biu_data_q;
    wdata_d    = wdata_q;
    rbuf_d     = rbuf_q;
    beat_d     = beat_q;
    last_d     = last_q;

    case (state_q)
      IDLE: begin
        if (i_biu_en) begin
          we_d    = (i_biu_func == `PCYN_BIU_FUNC_WRITE);
          wdata_d = i_biu_data;
          rbuf_d  = '0;
          beat_d  = '0;
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          if (i_biu_len == `PCYN_BIU_LEN_LINE) begin
            last_d    = LINE_LAST;
            wb_addr_d = i_biu_addr & LINE_MASK;
            sel_d     = '1;
            wb_data_d = i_biu_data[WBW-1:0];
          end else begin
            last_d    = '0;
            wb_addr_d = i_biu_addr & BUS_MASK;
            sel_d     = sub_sel(i_biu_len, off_s);
            wb_data_d = sub_wdata_s;
          end
          state_d = BUSY;
        end else begin
          state_d = IDLE;
        end
      end

      BUSY: begin
        if (i_wb_ack) begin
          if (!we_q) begin
            rbuf_d[int'(beat_q) * WBW +: WBW] = i_wb_data;
          end else begin
            rbuf_d = rbuf_q;
          end
          if (beat_q != last_q) begin
            // stb stays up so the slave may ack the next beat immediately
            beat_d    = beat_q + BEAT_W'(1);
            wb_addr_d = wb_addr_q + BEAT_STEP;
            wb_data_d = wdata_q[(int'(beat_q) + 1) * WBW +: WBW];
          end else begin
            cyc_d      = 1'b0;
            stb_d      = 1'b0;
            we_d       = 1'b0;
            done_d     = 1'b1;
            biu_data_d = rbuf_d;
            state_d    = DONE;
          end
        end else begin
          state_d = BUSY;
        end
      end

      DONE: begin
        // wait for the arbiter to drop en so a held request is not replayed
        if (!i_biu_en) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end

      default: begin
        state_d = IDLE;
        cyc_d   = 1'b0;
        stb_d   = 1'b0;
        we_d    = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops the bus cycle at once.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= IDLE;
      cyc_q      <= 1'b0;
      stb_q      <= 1'b0;
      we_q       <= 1'b0;
      sel_q      <= '0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
      done_q     <= 1'b0;
      biu_data_q <= '0;
      wdata_q    <= '0;
      rbuf_q     <= '0;
      beat_q     <= '0;
      last_q     <= '0;
    end else begin
      state_q    <= state_d;
      cyc_q      <= cyc_d;
      stb_q      <= stb_d;
      we_q       <= we_d;
      sel_q      <= sel_d;
      wb_addr_q  <= wb_addr_d;
      wb_data_q  <= wb_data_d;
      done_q     <= done_d;
      biu_data_q <= biu_data_d;
      wdata_q    <= wdata_d;
      rbuf_q     <= rbuf_d;
      beat_q     <= beat_d;
      last_q     <= last_d;
    end
  end

  assign o_wb_cyc   = cyc_q;
  assign o_wb_stb   = stb_q;
  assign o_wb_we    = we_q;
  assign o_wb_sel   = sel_q;
  assign o_wb_addr  = wb_addr_q;
  assign o_wb_data  = wb_data_q;
  assign o_biu_done = done_q;
  assign o_biu_data = biu_data_q;

endmodule
